// File: rtl/instr_sequencer.sv
// Multi-cycle fetch/decode/execute/writeback sequencer for the 8-bit core.
// Owns the program counter and the instruction register. Walks each
// instruction through register-file read, ALU execute and writeback
// according to the opcode returned by the control unit.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | out of reset, waiting for start
// FETCH   | imem_rd held at address pc until imem_valid
// DECODE  | opcode/number/flag_CU sampled; branch, halt or dispatch
// READ    | one-cycle register-file read strobe
// EXEC    | ALU launched on the first cycle, waits for alu_done or timeout
// WB      | one-cycle register-file write strobe
// HALTED  | stopped by HALT or ALU timeout; start restarts from pc 0
module instr_sequencer #(
    parameter int PC_W    = 8,
    parameter int TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    output logic [PC_W-1:0] imem_addr,
    output logic            imem_rd,
    input  logic [31:0]     imem_data,
    input  logic            imem_valid,
    output logic [31:0]     instruction,
    input  logic [3:0]      opcode,
    input  logic [7:0]      number,
    input  logic [3:0]      flag_CU,
    output logic            rf_rd,
    output logic            alu_start,
    input  logic            alu_done,
    output logic            rf_we,
    output logic            wb_sel,
    output logic            busy,
    output logic            halted,
    output logic            err,
    output logic [PC_W-1:0] pc,
    output logic [15:0]     retired
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_READ,
        S_EXEC,
        S_WB,
        S_HALTED
    } state_t;

    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_LOADI = 4'hA;
    localparam logic [3:0] OP_JMP   = 4'hB;
    localparam logic [3:0] OP_BZ    = 4'hC;
    localparam logic [3:0] OP_HALT  = 4'hF;

    // Last EXEC cycle index before the ALU is declared hung.
    localparam logic [7:0] TCNT_LAST = 8'(TIMEOUT - 1);

    state_t          state_q;
    logic [PC_W-1:0] pc_q;
    logic [31:0]     instr_q;
    logic [15:0]     retired_q;
    logic [15:0]     retired_d;
    logic            err_q;
    logic            wb_sel_q;
    logic [7:0]      tcnt_q;

    // Only the zero flag steers branching; the other flag bits are not needed.
    logic unused_flags;
    assign unused_flags = ^flag_CU[3:1];

    // Saturating increment of the retired-instruction counter.
    always_comb begin
        retired_d = retired_q;
        if (retired_q != 16'hFFFF) begin
            retired_d = retired_q + 16'd1;
        end
    end

    // Sequencer state machine, program counter and status registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            pc_q      <= '0;
            instr_q   <= '0;
            retired_q <= '0;
            err_q     <= 1'b0;
            wb_sel_q  <= 1'b0;
            tcnt_q    <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (imem_valid) begin
                        instr_q <= imem_data;
                        pc_q    <= pc_q + PC_W'(1);
                        state_q <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    case (opcode)
                        OP_HALT: begin
                            state_q <= S_HALTED;
                        end
                        OP_NOP: begin
                            retired_q <= retired_d;
                            state_q   <= S_FETCH;
                        end
                        OP_JMP: begin
                            pc_q      <= PC_W'(number);
                            retired_q <= retired_d;
                            state_q   <= S_FETCH;
                        end
                        OP_BZ: begin
                            if (flag_CU[0]) begin
                                pc_q <= PC_W'(number);
                            end
                            retired_q <= retired_d;
                            state_q   <= S_FETCH;
                        end
                        OP_LOADI: begin
                            wb_sel_q <= 1'b1;
                            state_q  <= S_WB;
                        end
                        default: begin
                            wb_sel_q <= 1'b0;
                            state_q  <= S_READ;
                        end
                    endcase
                end
                S_READ: begin
                    tcnt_q  <= '0;
                    state_q <= S_EXEC;
                end
                S_EXEC: begin
                    // alu_done in the launch cycle belongs to no operation of ours.
                    if ((tcnt_q != 8'd0) && alu_done) begin
                        state_q <= S_WB;
                    end else if (tcnt_q == TCNT_LAST) begin
                        err_q   <= 1'b1;
                        state_q <= S_HALTED;
                    end else begin
                        tcnt_q <= tcnt_q + 8'd1;
                    end
                end
                S_WB: begin
                    retired_q <= retired_d;
                    state_q   <= S_FETCH;
                end
                S_HALTED: begin
                    if (start) begin
                        pc_q    <= '0;
                        instr_q <= '0;
                        err_q   <= 1'b0;
                        state_q <= S_FETCH;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign instruction = instr_q;
    assign retired     = retired_q;
    assign err         = err_q;
    assign wb_sel      = wb_sel_q;
    assign imem_rd     = (state_q == S_FETCH);
    assign rf_rd       = (state_q == S_READ);
    assign alu_start   = (state_q == S_EXEC) && (tcnt_q == 8'd0);
    assign rf_we       = (state_q == S_WB);
    assign halted      = (state_q == S_HALTED);
    assign busy        = (state_q != S_IDLE) && (state_q != S_HALTED);

endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench for instr_sequencer: directed programs, an instruction
// memory with programmable latency, a simple ALU responder and a monitor
// that pops expected events whenever the DUT shows an observable action.
module tb_instr_sequencer;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  imem_addr;
    logic        imem_rd;
    logic [31:0] imem_data;
    logic        imem_valid;
    logic [31:0] instruction;
    logic [3:0]  opcode;
    logic [7:0]  number;
    logic [3:0]  flag_CU;
    logic        rf_rd;
    logic        alu_start;
    logic        alu_done;
    logic        rf_we;
    logic        wb_sel;
    logic        busy;
    logic        halted;
    logic        err;
    logic [7:0]  pc;
    logic [15:0] retired;

    instr_sequencer #(.PC_W(8), .TIMEOUT(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .imem_addr   (imem_addr),
        .imem_rd     (imem_rd),
        .imem_data   (imem_data),
        .imem_valid  (imem_valid),
        .instruction (instruction),
        .opcode      (opcode),
        .number      (number),
        .flag_CU     (flag_CU),
        .rf_rd       (rf_rd),
        .alu_start   (alu_start),
        .alu_done    (alu_done),
        .rf_we       (rf_we),
        .wb_sel      (wb_sel),
        .busy        (busy),
        .halted      (halted),
        .err         (err),
        .pc          (pc),
        .retired     (retired)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Stand-in control unit: opcode [31:28], flags [11:8], number [7:0].
    assign opcode  = instruction[31:28];
    assign flag_CU = instruction[11:8];
    assign number  = instruction[7:0];

    function automatic logic [31:0] mk(input logic [3:0] op, input logic [7:0] num,
                                       input logic [3:0] fl);
        return {op, 16'h0000, fl, num};
    endfunction

    localparam logic [3:0] NOP = 4'h0, LDI = 4'hA, JMP = 4'hB, BZ = 4'hC, HLT = 4'hF;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- instruction memory ----------------
    logic [31:0] mem [256];
    int          mem_lat;
    int          wcnt;
    logic        valid_r;
    logic        force_valid;
    assign imem_valid = valid_r | force_valid;

    always @(negedge clk) begin
        valid_r = 1'b0;
        if (imem_rd) begin
            if (wcnt >= mem_lat) begin
                valid_r   = 1'b1;
                imem_data = mem[imem_addr];
                wcnt      = 0;
            end else begin
                wcnt++;
            end
        end else begin
            wcnt = 0;
        end
    end

    // ---------------- ALU responder ----------------
    int   alu_lat;
    int   alu_cnt;
    logic done_r;
    logic force_done;
    assign alu_done = done_r | force_done;

    always @(negedge clk) begin
        if (alu_cnt > 0) begin
            alu_cnt--;
            done_r = (alu_cnt == 0);
        end else begin
            done_r = 1'b0;
        end
        if (alu_start && alu_lat > 0) alu_cnt = alu_lat;
    end

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic [7:0]  kind;
        logic [31:0] val;
    } ev_t;

    ev_t  exq[$];
    logic halted_prev;

    task automatic expect_ev(input logic [7:0] k, input logic [31:0] v);
        ev_t e;
        e.kind = k;
        e.val  = v;
        exq.push_back(e);
    endtask

    function automatic logic [31:0] hv(input logic e, input logic [15:0] r, input logic [7:0] p);
        return {7'd0, e, r, p};
    endfunction

    task automatic observe(input logic [7:0] k, input logic [31:0] v);
        ev_t e;
        if (exq.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_event: got %c/%0h expected none", k, v);
        end else begin
            e = exq.pop_front();
            chk($sformatf("event_%c", e.kind), {24'd0, k, v}, {24'd0, e.kind, e.val});
        end
    endtask

    always @(negedge clk) begin
        #1;
        if (rst_n) begin
            if (imem_rd && imem_valid) observe("F", {24'd0, imem_addr});
            if (rf_rd)                 observe("R", 32'd0);
            if (alu_start)             observe("S", 32'd0);
            if (rf_we)                 observe("W", {31'd0, wb_sel});
            if (halted && !halted_prev) observe("H", hv(err, retired, pc));
        end
        halted_prev = halted;
    end

    // ---------------- helpers ----------------
    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = mk(HLT, 8'h00, 4'h0);
    endtask

    task automatic go();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_halt(input string name, input int maxc);
        int n = 0;
        while (!halted && n < maxc) begin
            @(negedge clk);
            n++;
        end
        if (!halted) chk({name, "_halt_timeout"}, 64'd0, 64'd1);
        repeat (3) @(negedge clk);
        chk({name, "_pending_events"}, 64'(exq.size()), 64'd0);
    endtask

    task automatic wait_sig_start(input string name, input int maxc);
        int n = 0;
        while (!alu_start && n < maxc) begin
            @(negedge clk);
            n++;
        end
        if (!alu_start) chk({name, "_alu_start_timeout"}, 64'd0, 64'd1);
    endtask

    function automatic logic [63:0] all_outs();
        return {3'd0, busy, halted, err, imem_rd, rf_rd, alu_start, rf_we, wb_sel,
                imem_addr, pc, retired, instruction[12:0]};
    endfunction

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        int n;
        rst_n = 1'b0; start = 1'b0;
        mem_lat = 0; wcnt = 0; valid_r = 1'b0; force_valid = 1'b0; imem_data = '0;
        alu_lat = 0; alu_cnt = 0; done_r = 1'b0; force_done = 1'b0;
        halted_prev = 1'b0;
        clear_mem();
        repeat (3) @(negedge clk);
        chk("reset_outputs", all_outs(), 64'd0);
        chk("reset_instruction", {32'd0, instruction}, 64'd0);
        rst_n = 1'b1;

        // 1: LOADI 5, NOP, HALT with zero-latency memory
        mem[0] = mk(LDI, 8'h05, 4'h0);
        mem[1] = mk(NOP, 8'h00, 4'h0);
        mem[2] = mk(HLT, 8'h00, 4'h0);
        expect_ev("F", 0); expect_ev("W", 1); expect_ev("F", 1); expect_ev("F", 2);
        expect_ev("H", hv(1'b0, 16'd2, 8'd3));
        go();
        wait_halt("t1", 50);
        chk("t1_pc", 64'(pc), 64'd3);
        chk("t1_retired", 64'(retired), 64'd2);

        // 2: ALU op, alu_done 3 cycles after alu_start, memory latency 2
        clear_mem();
        mem_lat = 2; alu_lat = 3;
        mem[0] = mk(4'h3, 8'h00, 4'h0);
        expect_ev("F", 0); expect_ev("R", 0); expect_ev("S", 0); expect_ev("W", 0);
        expect_ev("F", 1); expect_ev("H", hv(1'b0, 16'd3, 8'd2));
        go();
        wait_halt("t2", 60);
        chk("t2_err", 64'(err), 64'd0);

        // 3: BZ taken to 0x40, then BZ not taken falls through to 0x41
        clear_mem();
        mem_lat = 1;
        mem[0]     = mk(BZ, 8'h40, 4'h1);
        mem[8'h40] = mk(BZ, 8'h80, 4'h0);
        expect_ev("F", 0); expect_ev("F", 32'h40); expect_ev("F", 32'h41);
        expect_ev("H", hv(1'b0, 16'd5, 8'h42));
        go();
        wait_halt("t3", 60);

        // 4a: JMP 0x00 from 0xFF, HALT placed at 0 once 0xFF is being fetched
        clear_mem();
        mem_lat = 0;
        mem[0]     = mk(JMP, 8'hFF, 4'h0);
        mem[8'hFF] = mk(JMP, 8'h00, 4'h0);
        expect_ev("F", 0); expect_ev("F", 32'hFF); expect_ev("F", 0);
        expect_ev("H", hv(1'b0, 16'd7, 8'h01));
        go();
        n = 0;
        while (!(imem_rd && imem_addr == 8'hFF) && n < 20) begin @(negedge clk); n++; end
        chk("t4a_reach_ff", 64'(imem_addr), 64'hFF);
        mem[0] = mk(HLT, 8'h00, 4'h0);
        wait_halt("t4a", 40);

        // 4b: NOP at 0xFF, pc wraps to 0 on the increment
        clear_mem();
        mem[0]     = mk(JMP, 8'hFF, 4'h0);
        mem[8'hFF] = mk(NOP, 8'h00, 4'h0);
        expect_ev("F", 0); expect_ev("F", 32'hFF); expect_ev("F", 0);
        expect_ev("H", hv(1'b0, 16'd9, 8'h01));
        go();
        n = 0;
        while (!(imem_rd && imem_addr == 8'hFF) && n < 20) begin @(negedge clk); n++; end
        mem[0] = mk(HLT, 8'h00, 4'h0);
        @(negedge clk);
        chk("t4b_pc_wrap", 64'(pc), 64'd0);
        wait_halt("t4b", 40);

        // 5: ALU never answers -> timeout after 16 EXEC cycles
        clear_mem();
        alu_lat = 0;
        mem[0] = mk(4'h5, 8'h00, 4'h0);
        expect_ev("F", 0); expect_ev("R", 0); expect_ev("S", 0);
        expect_ev("H", hv(1'b1, 16'd9, 8'h01));
        go();
        wait_sig_start("t5", 20);
        n = 0;
        while (!halted && n < 40) begin @(negedge clk); n++; end
        chk("t5_exec_cycles", 64'(n), 64'd16);
        wait_halt("t5", 10);
        chk("t5_err_set", 64'(err), 64'd1);
        mem[0] = mk(HLT, 8'h00, 4'h0);
        expect_ev("F", 0); expect_ev("H", hv(1'b0, 16'd9, 8'h01));
        go();
        chk("t5_restart", {62'd0, err, imem_rd} | 64'(imem_addr) << 8, 64'd1);
        wait_halt("t5r", 20);

        // 6a: reset in the middle of EXEC
        clear_mem();
        mem[0] = mk(4'h2, 8'h00, 4'h0);
        expect_ev("F", 0); expect_ev("R", 0); expect_ev("S", 0);
        go();
        wait_sig_start("t6", 20);
        repeat (2) @(negedge clk);
        chk("t6_in_exec", 64'(busy), 64'd1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("t6_rst_exec", all_outs(), 64'd0);
        rst_n = 1'b1;
        force_valid = 1'b1; force_done = 1'b1;
        @(negedge clk);
        force_valid = 1'b0; force_done = 1'b0;
        @(negedge clk);
        chk("t6_idle_ignores", all_outs(), 64'd0);

        // 6b: reset while a fetch is outstanding
        mem_lat = 20;
        go();
        repeat (2) @(negedge clk);
        chk("t6_in_fetch", 64'(imem_rd), 64'd1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("t6_rst_fetch", all_outs(), 64'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("t6_pending_events", 64'(exq.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
